// File: rtl/matched_filter_sequencer_if.sv
// matched_filter_sequencer_if
// Bundles the control, sample-source, matched-filter and detection-record
// signals of the matched filter sequencer.
//   master : the environment (control, sample source, filter score side)
//   slave  : the sequencer itself
// Signals:
//   start/stop         framing control pulses
//   threshold          detection threshold (unsigned)
//   s_axii{v,d}/s_axiir source sample handshake
//   mf_axio{v,d}       sample stream into the matched filter
//   mf_score_valid/mf_score  score returned by the filter
//   det_*              one detection record per frame
//   busy               sequencer not idle
interface matched_filter_sequencer_if #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int MATCH_SCORE_WIDTH = 16,
  parameter int FRAME_COUNT_WIDTH = 16
);
  logic                         start;
  logic                         stop;
  logic [MATCH_SCORE_WIDTH-1:0] threshold;
  logic                         s_axiiv;
  logic [SAMPLE_DATA_WIDTH-1:0] s_axiid;
  logic                         s_axiir;
  logic                         mf_axiov;
  logic [SAMPLE_DATA_WIDTH-1:0] mf_axiod;
  logic                         mf_score_valid;
  logic [MATCH_SCORE_WIDTH-1:0] mf_score;
  logic                         det_valid;
  logic                         det_hit;
  logic [1:0]                   det_status;
  logic [MATCH_SCORE_WIDTH-1:0] det_score;
  logic [FRAME_COUNT_WIDTH-1:0] det_frame;
  logic                         busy;

  modport master (
    output start, stop, threshold, s_axiiv, s_axiid, mf_score_valid, mf_score,
    input  s_axiir, mf_axiov, mf_axiod, det_valid, det_hit, det_status,
           det_score, det_frame, busy
  );

  modport slave (
    input  start, stop, threshold, s_axiiv, s_axiid, mf_score_valid, mf_score,
    output s_axiir, mf_axiov, mf_axiod, det_valid, det_hit, det_status,
           det_score, det_frame, busy
  );
endinterface

// File: rtl/matched_filter_sequencer.sv
// matched_filter_sequencer
// Cuts the incoming sample stream into contiguous windows of FRAME_LENGTH
// samples, forwards them (one cycle late) to the matched filter, waits for
// the filter's score, compares it to the threshold latched at frame start
// and emits one detection record per frame.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  matched_filter_sequencer_if.slave (control, source, filter, record)
module matched_filter_sequencer #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int MATCH_SCORE_WIDTH = 16,
  parameter int FRAME_LENGTH      = 2000,
  parameter int SCORE_TIMEOUT     = 64,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  matched_filter_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(FRAME_LENGTH + 1);
  localparam int TO_W  = $clog2(SCORE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(SCORE_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [FRAME_COUNT_WIDTH-1:0] FR_ONE = FRAME_COUNT_WIDTH'(1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SCORE, REPORT} state_e;

  state_e                         state_q;
  logic [CNT_W-1:0]               sample_cnt_q;
  logic [TO_W-1:0]                wait_cnt_q;
  logic [FRAME_COUNT_WIDTH-1:0]   frame_cnt_q;
  logic [MATCH_SCORE_WIDTH-1:0]   thr_q;
  logic                           stop_pend_q;
  logic                           mf_axiov_q;
  logic [SAMPLE_DATA_WIDTH-1:0]   mf_axiod_q;
  logic                           det_valid_q;
  logic                           det_hit_q;
  logic [1:0]                     det_status_q;
  logic [MATCH_SCORE_WIDTH-1:0]   det_score_q;
  logic [FRAME_COUNT_WIDTH-1:0]   det_frame_q;

  logic                           accept;
  logic                           rep_go_d;
  logic [1:0]                     rep_status_d;
  logic [MATCH_SCORE_WIDTH-1:0]   rep_score_d;

  assign accept        = bus.s_axiiv && (state_q == FILL);
  assign bus.s_axiir   = (state_q == FILL);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mf_axiov  = mf_axiov_q;
  assign bus.mf_axiod  = mf_axiod_q;
  assign bus.det_valid = det_valid_q;
  assign bus.det_hit   = det_hit_q;
  assign bus.det_status = det_status_q;
  assign bus.det_score = det_score_q;
  assign bus.det_frame = det_frame_q;

  // Frame-ending events that produce a record on the next cycle.
  always_comb begin
    rep_go_d     = 1'b0;
    rep_status_d = ST_OK;
    rep_score_d  = '0;
    case (state_q)
      FILL: begin
        // A gap inside a frame would clear the filter mid-window: abort.
        if (!accept && (sample_cnt_q != '0)) begin
          rep_go_d     = 1'b1;
          rep_status_d = ST_ABORT;
        end
      end
      WAIT_SCORE: begin
        if (bus.mf_score_valid) begin
          rep_go_d    = 1'b1;
          rep_score_d = bus.mf_score;
        end else if (wait_cnt_q == TO_MAX) begin
          rep_go_d     = 1'b1;
          rep_status_d = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      wait_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      thr_q        <= '0;
      stop_pend_q  <= 1'b0;
      mf_axiov_q   <= 1'b0;
      mf_axiod_q   <= '0;
      det_valid_q  <= 1'b0;
      det_hit_q    <= 1'b0;
      det_status_q <= '0;
      det_score_q  <= '0;
      det_frame_q  <= '0;
    end else begin
      mf_axiov_q  <= accept;
      if (accept) mf_axiod_q <= bus.s_axiid;
      det_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_q      <= FILL;
            sample_cnt_q <= '0;
            thr_q        <= bus.threshold;
          end
        end
        FILL: begin
          if (bus.stop && (sample_cnt_q == '0)) begin
            // Nothing in flight yet: stop immediately.
            state_q <= IDLE;
          end else begin
            if (bus.stop) stop_pend_q <= 1'b1;
            if (accept) begin
              if (sample_cnt_q == LAST_IDX) begin
                state_q    <= WAIT_SCORE;
                wait_cnt_q <= '0;
              end
              sample_cnt_q <= sample_cnt_q + CNT_ONE;
            end
          end
        end
        WAIT_SCORE: begin
          if (bus.stop) stop_pend_q <= 1'b1;
          if (!rep_go_d) wait_cnt_q <= wait_cnt_q + TO_ONE;
        end
        REPORT: begin
          // A stop arriving on the report cycle itself still ends framing here.
          if (stop_pend_q || bus.stop) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
          end else begin
            state_q      <= FILL;
            sample_cnt_q <= '0;
            thr_q        <= bus.threshold;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (rep_go_d) begin
        state_q      <= REPORT;
        det_valid_q  <= 1'b1;
        det_status_q <= rep_status_d;
        det_score_q  <= rep_score_d;
        det_hit_q    <= (rep_status_d == ST_OK) && (rep_score_d >= thr_q);
        det_frame_q  <= frame_cnt_q;
        frame_cnt_q  <= frame_cnt_q + FR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_matched_filter_sequencer.sv
module tb_matched_filter_sequencer;
  localparam int SDW = 8;
  localparam int MSW = 16;
  localparam int FL  = 4;
  localparam int TO  = 8;
  localparam int FCW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matched_filter_sequencer_if #(
    .SAMPLE_DATA_WIDTH(SDW), .MATCH_SCORE_WIDTH(MSW), .FRAME_COUNT_WIDTH(FCW)
  ) bus ();

  matched_filter_sequencer #(
    .SAMPLE_DATA_WIDTH(SDW), .MATCH_SCORE_WIDTH(MSW), .FRAME_LENGTH(FL),
    .SCORE_TIMEOUT(TO), .FRAME_COUNT_WIDTH(FCW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic           hit;
    logic [1:0]     st;
    logic [MSW-1:0] sc;
    logic [FCW-1:0] fr;
  } rec_t;

  rec_t           exp_det[$];
  logic [SDW-1:0] exp_mf[$];
  rec_t           mon_r;
  logic [SDW-1:0] mon_e;
  int             checks = 0;
  int             errors = 0;
  int             exp_frame = 0;
  logic [MSW-1:0] thr = 16'd8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every forwarded sample and every record is popped here.
  always @(negedge clk) begin
    if (bus.mf_axiov === 1'b1) begin
      checks++;
      assert (exp_mf.size() != 0) else begin
        errors++;
        $error("FAIL mf_unexpected: observed sample %0h expected none", bus.mf_axiod);
      end
      if (exp_mf.size() != 0) begin
        mon_e = exp_mf.pop_front();
        chk("mf_axiod", 32'(bus.mf_axiod), 32'(mon_e));
      end
    end
    if (bus.det_valid === 1'b1) begin
      checks++;
      assert (exp_det.size() != 0) else begin
        errors++;
        $error("FAIL det_unexpected: observed record frame %0d expected none", bus.det_frame);
      end
      if (exp_det.size() != 0) begin
        mon_r = exp_det.pop_front();
        chk("det_hit",    32'(bus.det_hit),    32'(mon_r.hit));
        chk("det_status", 32'(bus.det_status), 32'(mon_r.st));
        chk("det_score",  32'(bus.det_score),  32'(mon_r.sc));
        chk("det_frame",  32'(bus.det_frame),  32'(mon_r.fr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [1:0] st, input int sc);
    rec_t r;
    r.st  = st;
    r.sc  = MSW'(sc);
    r.hit = (st == 2'b00) && (MSW'(sc) >= thr);
    r.fr  = FCW'(exp_frame);
    exp_frame++;
    exp_det.push_back(r);
  endtask

  task automatic send1(input int d, input logic st, input logic sp);
    chk("s_axiir_fill", 32'(bus.s_axiir), 32'd1);
    bus.s_axiiv = 1'b1;
    bus.s_axiid = SDW'(d);
    bus.start   = st;
    bus.stop    = sp;
    exp_mf.push_back(SDW'(d));
    tick();
    bus.s_axiiv = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) send1(base + i, 1'b0, 1'b0);
  endtask

  task automatic score(input int v);
    bus.mf_score_valid = 1'b1;
    bus.mf_score       = MSW'(v);
    tick();
    bus.mf_score_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_axiir"},    32'(bus.s_axiir),    32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_mf_axiov"},   32'(bus.mf_axiov),   32'd0);
    chk({tag, "_mf_axiod"},   32'(bus.mf_axiod),   32'd0);
    chk({tag, "_det_valid"},  32'(bus.det_valid),  32'd0);
    chk({tag, "_det_hit"},    32'(bus.det_hit),    32'd0);
    chk({tag, "_det_status"}, 32'(bus.det_status), 32'd0);
    chk({tag, "_det_score"},  32'(bus.det_score),  32'd0);
    chk({tag, "_det_frame"},  32'(bus.det_frame),  32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.threshold = thr;
    bus.s_axiiv = 1'b0; bus.s_axiid = '0;
    bus.mf_score_valid = 1'b0; bus.mf_score = '0;

    // Reset held for 5 cycles.
    repeat (5) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // start and stop together in IDLE: stays idle.
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("start_stop_busy2", 32'(bus.busy), 32'd0);

    // Frame 0: samples 1..4, score 10 two cycles after the last sample.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    push_rec(2'b00, 10);
    send(4, 1);
    chk("wait_s_axiir", 32'(bus.s_axiir), 32'd0);
    chk("wait_mf_axiov", 32'(bus.mf_axiov), 32'd1);
    chk("wait_mf_last", 32'(bus.mf_axiod), 32'd4);
    tick();
    chk("mf_axiov_low", 32'(bus.mf_axiov), 32'd0);
    score(10);
    chk("det_at_s_plus1", 32'(bus.det_valid), 32'd1);
    chk("report_s_axiir", 32'(bus.s_axiir), 32'd0);
    tick();
    chk("det_one_cycle", 32'(bus.det_valid), 32'd0);
    chk("refill_s_axiir", 32'(bus.s_axiir), 32'd1);
    chk("det_hit_hold", 32'(bus.det_hit), 32'd1);
    chk("det_score_hold", 32'(bus.det_score), 32'd10);

    // Frame 1: score 7 below threshold.
    push_rec(2'b00, 7);
    send(4, 11);
    tick();
    score(7);
    tick();

    // Frame 2: source gap after two samples aborts.
    push_rec(2'b01, 0);
    send(2, 21);
    tick();
    chk("abort_det", 32'(bus.det_valid), 32'd1);
    chk("abort_s_axiir", 32'(bus.s_axiir), 32'd0);
    tick();
    // Frame 3: restarts from sample 0 and completes.
    push_rec(2'b00, 9);
    send(4, 31);
    chk("restart_wait", 32'(bus.s_axiir), 32'd0);
    tick();
    score(9);
    tick();

    // Frame 0 (wrapped): no score -> timeout 9 cycles after entering WAIT_SCORE.
    push_rec(2'b10, 0);
    send(4, 41);
    for (int k = 0; k < TO; k++) begin
      tick();
      chk("timeout_early", 32'(bus.det_valid), 32'd0);
    end
    tick();
    chk("timeout_det", 32'(bus.det_valid), 32'd1);
    tick();
    // Late score in FILL is ignored.
    score(99);
    chk("late_score_no_det", 32'(bus.det_valid), 32'd0);
    chk("late_score_fill", 32'(bus.s_axiir), 32'd1);
    tick();

    // Frame 1: stop during sample 2, start during sample 3; score == threshold.
    push_rec(2'b00, 8);
    send1(51, 1'b0, 1'b0);
    send1(52, 1'b0, 1'b1);
    send1(53, 1'b1, 1'b0);
    send1(54, 1'b0, 1'b0);
    chk("stop_wait", 32'(bus.s_axiir), 32'd0);
    tick();
    score(8);
    chk("stop_det", 32'(bus.det_valid), 32'd1);
    tick();
    chk("stop_idle_busy", 32'(bus.busy), 32'd0);
    chk("stop_idle_ready", 32'(bus.s_axiir), 32'd0);
    tick();
    tick();
    chk("stop_idle_stays", 32'(bus.busy), 32'd0);

    // Frame counter wrap after a fresh reset.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_frame = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int f = 0; f < 5; f++) begin
      push_rec(2'b00, (f == 2) ? 200 : 5 + f);
      send(4, 60 + 4 * f);
      tick();
      score((f == 2) ? 200 : 5 + f);
      tick();
    end
    // Reset in the middle of a frame: no record.
    send(2, 90);
    bus.s_axiiv = 1'b1;
    bus.s_axiid = 8'd92;
    rst = 1'b1;
    tick();
    chk_all_zero("mid_fill_rst");
    bus.s_axiiv = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    chk("det_queue_empty", 32'(exp_det.size()), 32'd0);
    chk("mf_queue_empty", 32'(exp_mf.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matched_filter_sequencer.md
# matched_filter_sequencer

Frames the incoming sample stream into contiguous windows of FRAME_LENGTH samples and drives them into the matched filter. Between windows it holds the filter's valid low so the accumulator clears. It then collects each window's match score, compares it against a programmable threshold and reports one detection record per frame. It sits between the sample source (ADC or capture buffer) and the matched filter and owns all start/stop sequencing of that datapath.

## Interface
- SAMPLE_DATA_WIDTH, 8, sample width (matches filter input)
- MATCH_SCORE_WIDTH, 16, score/threshold width
- FRAME_LENGTH, 2000, samples per frame, ≥2
- SCORE_TIMEOUT, 64, max cycles waited for a score, ≥1
- FRAME_COUNT_WIDTH, 16, frame index width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse, begin framing
- stop  in  1  one-cycle pulse, stop at next frame boundary
- threshold  in  MATCH_SCORE_WIDTH  detection threshold, unsigned
- s_axiiv  in  1  source sample valid
- s_axiid  in  SAMPLE_DATA_WIDTH  source sample
- s_axiir  out  1  ready to source
- mf_axiov  out  1  filter sample valid
- mf_axiod  out  SAMPLE_DATA_WIDTH  filter sample
- mf_score_valid  in  1  filter score strobe
- mf_score  in  MATCH_SCORE_WIDTH  filter score
- det_valid  out  1  one-cycle detection record strobe
- det_hit  out  1  score ≥ threshold on a good frame
- det_status  out  2  00 ok, 01 aborted, 10 timeout
- det_score  out  MATCH_SCORE_WIDTH  captured score (0 if aborted/timeout)
- det_frame  out  FRAME_COUNT_WIDTH  frame index of this record
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, FILL, WAIT_SCORE, REPORT.
- IDLE:
  - s_axiir=0.
  - start (and not stop the same cycle) → FILL with sample_cnt=0; threshold latched.
- FILL:
  - s_axiir=1. An accepted sample (s_axiiv & s_axiir) increments sample_cnt.
  - Accepting sample FRAME_LENGTH → WAIT_SCORE.
  - s_axiiv=0 with sample_cnt=0: wait in FILL.
  - s_axiiv=0 with sample_cnt>0: abort, go to REPORT with status 01. A frame must be contiguous because the filter clears on any invalid cycle.
- WAIT_SCORE:
  - s_axiir=0.
  - mf_score_valid → capture mf_score, go to REPORT with status 00.
  - Wait counter reaches SCORE_TIMEOUT with no score → REPORT with status 10.
  - mf_score_valid outside WAIT_SCORE is ignored.
- REPORT (one cycle):
  - det_valid=1; det_hit = (status==00) & (score ≥ latched threshold), unsigned.
  - det_frame = frame counter; frame counter increments and wraps at 2^FRAME_COUNT_WIDTH.
  - If stop_pending → IDLE and clear stop_pending; else → FILL with sample_cnt=0 and re-latch threshold.
- stop:
  - In IDLE, or in FILL with sample_cnt=0: go to IDLE next cycle.
  - Otherwise set stop_pending; the current frame completes and reports normally.
- start outside IDLE is ignored. start and stop together in IDLE: stay IDLE.
- Filter drive: mf_axiov/mf_axiod are registered copies of the accepted sample. mf_axiov=0 on any cycle without an accepted sample.
- Counters: sample_cnt is $clog2(FRAME_LENGTH+1) bits; timeout counter is $clog2(SCORE_TIMEOUT+1) bits. All compares are unsigned.
- Reset: state IDLE, all outputs 0, all counters 0, stop_pending 0. Reset mid-frame discards the frame with no record.

## Timing
- mf_axiov/mf_axiod lag the s_axiiv/s_axiid handshake by exactly 1 cycle.
- Last sample accepted at cycle T:
  - T+1: state WAIT_SCORE, s_axiir=0, last sample on mf_axiod.
  - T+2 onward: mf_axiov=0.
- Score strobe at cycle S → det_valid at S+1. Next FILL (s_axiir=1) at S+2.
- Timeout: det_valid at exactly SCORE_TIMEOUT+1 cycles after entering WAIT_SCORE.
- Abort: invalid cycle at A → det_valid at A+1, s_axiir low at A+1.
- det_* fields hold their value until the next record. det_valid is high for exactly 1 cycle.

## Test plan
- Reset, then hold 5 cycles → all outputs 0, s_axiir=0, busy=0. start+stop in the same cycle → busy stays 0.
- FRAME_LENGTH=4, threshold=8. start, then samples 1,2,3,4 back-to-back; model returns score 10 two cycles after the last sample → mf_axiod 1,2,3,4 one cycle late; det_valid with hit=1, status=00, score=10, frame=0. Repeat with score 7 → hit=0, frame=1.
- Source drops s_axiiv after 2 samples → next cycle det_valid, status=01, hit=0, score=0. The following frame restarts at sample_cnt 0 and completes normally.
- SCORE_TIMEOUT=8, no mf_score_valid → det_valid 9 cycles after entering WAIT_SCORE, status=10. A late score strobe afterwards is ignored.
- stop during sample 2 of a frame → frame completes, record emitted, then IDLE with s_axiir=0. start mid-FILL has no effect.
- FRAME_COUNT_WIDTH=2, run 5 frames → det_frame 0,1,2,3,0. Assert rst mid-FILL → next cycle all outputs 0 and no record.
